// File: rtl/output_arbiter.sv
// Round-robin arbiter between the ALU result and keypad echo sources feeding the
// display driver, with a programmable idle gap after every downstream transfer.
module output_arbiter #(
  parameter int DATA_WIDTH      = 16,
  parameter int MIN_HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  input  logic                  i_res_2s_comp,
  input  logic                  i_res_valid,
  output logic                  o_res_ready,
  input  logic [DATA_WIDTH-1:0] i_key_data,
  input  logic                  i_key_2s_comp,
  input  logic                  i_key_valid,
  output logic                  o_key_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_2s_comp,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int CNT_W = (MIN_HOLD_CYCLES < 1) ? 1 : $clog2(MIN_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (MIN_HOLD_CYCLES > 0) ? CNT_W'(MIN_HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             last_grant;
  logic             grant_res;
  logic             grant_key;

  // last_grant=1 means requester 1 won last, so requester 0 takes the next tie.
  always_comb begin
    grant_res = 1'b0;
    grant_key = 1'b0;
    if (rst_n && state == IDLE) begin
      if (i_res_valid && (!i_key_valid || last_grant))
        grant_res = 1'b1;
      else if (i_key_valid)
        grant_key = 1'b1;
    end
  end

  assign o_res_ready = grant_res;
  assign o_key_ready = grant_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      o_data     <= '0;
      o_2s_comp  <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_res) begin
            o_data     <= i_res_data;
            o_2s_comp  <= i_res_2s_comp;
            last_grant <= 1'b0;
            o_valid    <= 1'b1;
            state      <= SEND;
          end else if (grant_key) begin
            o_data     <= i_key_data;
            o_2s_comp  <= i_key_2s_comp;
            last_grant <= 1'b1;
            o_valid    <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (MIN_HOLD_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              count <= HOLD_LOAD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (count == '0)
            state <= IDLE;
          else
            count <= count - 1'b1;
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: a MIN_HOLD_CYCLES=4 instance for most scenarios
// and a MIN_HOLD_CYCLES=0 instance sharing the same inputs for the no-gap case.
module tb_output_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] res_data, key_data;
  logic        res_2s, key_2s, res_valid, key_valid, ready_in;
  logic        res_ready, key_ready, valid, tc;
  logic [15:0] data;
  logic        res_ready0, key_ready0, valid0, tc0;
  logic [15:0] data0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  output_arbiter #(.DATA_WIDTH(16), .MIN_HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_res_data(res_data), .i_res_2s_comp(res_2s), .i_res_valid(res_valid), .o_res_ready(res_ready),
    .i_key_data(key_data), .i_key_2s_comp(key_2s), .i_key_valid(key_valid), .o_key_ready(key_ready),
    .o_data(data), .o_2s_comp(tc), .o_valid(valid), .i_ready(ready_in)
  );

  output_arbiter #(.DATA_WIDTH(16), .MIN_HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_res_data(res_data), .i_res_2s_comp(res_2s), .i_res_valid(res_valid), .o_res_ready(res_ready0),
    .i_key_data(key_data), .i_key_2s_comp(key_2s), .i_key_valid(key_valid), .o_key_ready(key_ready0),
    .o_data(data0), .o_2s_comp(tc0), .o_valid(valid0), .i_ready(ready_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    res_data = '0; key_data = '0; res_2s = 0; key_2s = 0;
    res_valid = 0; key_valid = 0; ready_in = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_valid = 1; key_valid = 1; ready_in = 1;
    res_data = 16'h1111; key_data = 16'h2222;
    #3;
    total++;
    if (res_ready !== 1'b0 || key_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got res=%b key=%b want 0/0", res_ready, key_ready);
    end
    step();
    total++;
    if (valid !== 1'b0 || data !== 16'h0000 || tc !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h tc=%b want 0/0000/0", valid, data, tc);
    end
  endtask

  task automatic test_first_tie();
    do_reset();
    res_data = 16'h1234; res_valid = 1;
    key_data = 16'h00AB; key_valid = 1;
    #1;
    total++;
    if (res_ready !== 1'b1 || key_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_tie_grant: got res=%b key=%b want 1/0", res_ready, key_ready);
    end
    step();
    res_valid = 0; key_valid = 0;
    total++;
    if (valid !== 1'b1 || data !== 16'h1234 || tc !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_tie_latency: got valid=%b data=%h tc=%b want 1/1234/0", valid, data, tc);
    end
  endtask

  task automatic test_round_robin();
    int          n;
    int          pulse_cyc [4];
    logic [15:0] pulse_data [4];
    logic [15:0] exp_data [4];
    exp_data = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    pulse_cyc = '{0, 0, 0, 0};
    pulse_data = '{16'h0, 16'h0, 16'h0, 16'h0};
    n = 0;
    do_reset();
    res_data = 16'h1111; key_data = 16'h2222;
    res_valid = 1; key_valid = 1; ready_in = 1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (valid) begin
        if (n < 4) begin
          pulse_cyc[n] = c;
          pulse_data[n] = data;
        end
        n++;
      end
    end
    res_valid = 0; key_valid = 0;
    total++;
    if (n !== 4) begin
      bad++;
      $display("[TB] FAIL rr_pulse_count: got %0d want 4", n);
    end
    total++;
    if (pulse_cyc[0] !== 1) begin
      bad++;
      $display("[TB] FAIL rr_first_pulse: got cycle %0d want 1", pulse_cyc[0]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pulse_data[i] !== exp_data[i]) begin
        bad++;
        $display("[TB] FAIL rr_grant_%0d: got %h want %h", i, pulse_data[i], exp_data[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (pulse_cyc[i] - pulse_cyc[i-1] !== 6) begin
        bad++;
        $display("[TB] FAIL rr_spacing_%0d: got %0d want 6", i, pulse_cyc[i] - pulse_cyc[i-1]);
      end
    end
  endtask

  task automatic test_backpressure_and_hold_gap();
    do_reset();
    key_data = 16'hFFFE; key_2s = 1; key_valid = 1;
    #1;
    total++;
    if (key_ready !== 1'b1 || res_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_key_grant: got res=%b key=%b want 0/1", res_ready, key_ready);
    end
    step();
    key_valid = 0; key_2s = 0; key_data = 16'h0000;
    res_data = 16'h7777; res_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (valid !== 1'b1 || data !== 16'hFFFE || tc !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b data=%h tc=%b want 1/fffe/1", i, valid, data, tc);
      end
      total++;
      if (res_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_ready_low_%0d: got res_ready=%b want 0", i, res_ready);
      end
      step();
    end
    ready_in = 1;
    step();
    total++;
    if (valid !== 1'b0 || data !== 16'hFFFE || tc !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_drop: got valid=%b data=%h tc=%b want 0/fffe/1", valid, data, tc);
    end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (res_ready !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL gap_hold_%0d: got res_ready=%b valid=%b want 0/0", k, res_ready, valid);
      end
      step();
    end
    total++;
    if (res_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gap_accept: got res_ready=%b want 1", res_ready);
    end
    step();
    res_valid = 0;
    total++;
    if (valid !== 1'b1 || data !== 16'h7777) begin
      bad++;
      $display("[TB] FAIL gap_send: got valid=%b data=%h want 1/7777", valid, data);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    res_data = 16'h5A5A; res_valid = 1; ready_in = 1;
    step();
    res_valid = 0;
    step();
    step();
    total++;
    if (valid !== 1'b0 || data !== 16'h5A5A) begin
      bad++;
      $display("[TB] FAIL rih_pre: got valid=%b data=%h want 0/5a5a", valid, data);
    end
    rst_n = 0;
    res_data = 16'h0C0C; res_valid = 1;
    #1;
    total++;
    if (data !== 16'h0000 || valid !== 1'b0 || res_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rih_async: got data=%h valid=%b res_ready=%b want 0000/0/0", data, valid, res_ready);
    end
    step();
    rst_n = 1;
    #1;
    total++;
    if (res_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rih_first_accept: got res_ready=%b want 1", res_ready);
    end
    step();
    res_valid = 0;
    total++;
    if (valid !== 1'b1 || data !== 16'h0C0C) begin
      bad++;
      $display("[TB] FAIL rih_send: got valid=%b data=%h want 1/0c0c", valid, data);
    end
  endtask

  task automatic test_idle_ready();
    do_reset();
    ready_in = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (valid !== 1'b0 || res_ready !== 1'b0 || key_ready !== 1'b0 || data !== 16'h0000) begin
        bad++;
        $display("[TB] FAIL idle_ready_%0d: got valid=%b res=%b key=%b data=%h want 0/0/0/0000",
                 i, valid, res_ready, key_ready, data);
      end
    end
    key_data = 16'h4321; key_valid = 1;
    #1;
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_still_idle: got key_ready=%b want 1", key_ready);
    end
    step();
    key_valid = 0;
    total++;
    if (valid !== 1'b1 || data !== 16'h4321) begin
      bad++;
      $display("[TB] FAIL idle_send: got valid=%b data=%h want 1/4321", valid, data);
    end
  endtask

  task automatic test_min_hold_zero();
    do_reset();
    res_data = 16'h0F0F; res_valid = 1; ready_in = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (valid0 !== c[0]) begin
        bad++;
        $display("[TB] FAIL mh0_valid_%0d: got %b want %b", c, valid0, c[0]);
      end
      total++;
      if (res_ready0 !== ~c[0]) begin
        bad++;
        $display("[TB] FAIL mh0_ready_%0d: got %b want %b", c, res_ready0, ~c[0]);
      end
    end
    total++;
    if (data0 !== 16'h0F0F) begin
      bad++;
      $display("[TB] FAIL mh0_data: got %h want 0f0f", data0);
    end
    res_valid = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_tie();
    test_round_robin();
    test_backpressure_and_hold_gap();
    test_reset_in_hold();
    test_idle_ready();
    test_min_hold_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
